// File: rtl/cc_speedticker_pkg.sv
// Shared definitions for the speed-timebase generator: FSM state encoding
// and the default limit constants used by the top and the limit calculator.
package cc_speedticker_pkg;

    typedef enum logic [1:0] {
        ST_SETUP  = 2'd0,
        ST_STROBE = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_DATAWIDTH       = 28;
    localparam int unsigned DEFAULT_LEVELWIDTH      = 3;
    localparam int unsigned DEFAULT_BASE_LIMIT      = 50_000_000;
    localparam int unsigned DEFAULT_STEP            = 5_000_000;
    localparam int unsigned DEFAULT_MIN_LIMIT       = 5_000_000;
    localparam int unsigned DEFAULT_TICKS_PER_LEVEL = 8;

endpackage

// File: rtl/cc_speedticker_limitcalc.sv
// Combinational limit function: BASE - level*STEP, clamped to MIN on borrow
// or when the difference falls below the floor.
module cc_speedticker_limitcalc
    import cc_speedticker_pkg::*;
#(
    parameter int unsigned SPEEDTICKER_DATAWIDTH  = DEFAULT_DATAWIDTH,
    parameter int unsigned SPEEDTICKER_LEVELWIDTH = DEFAULT_LEVELWIDTH,
    parameter int unsigned SPEEDTICKER_BASE_LIMIT = DEFAULT_BASE_LIMIT,
    parameter int unsigned SPEEDTICKER_STEP       = DEFAULT_STEP,
    parameter int unsigned SPEEDTICKER_MIN_LIMIT  = DEFAULT_MIN_LIMIT
) (
    input  logic [SPEEDTICKER_LEVELWIDTH-1:0] level_i,
    output logic [SPEEDTICKER_DATAWIDTH-1:0]  limit_o
);

    localparam int unsigned DW = SPEEDTICKER_DATAWIDTH;
    localparam int unsigned XW = SPEEDTICKER_DATAWIDTH + 1;

    logic [63:0]   product;
    logic [XW-1:0] diff;
    logic          borrow;

    // The product is formed wide so a large level*STEP can never alias back
    // into a small in-range difference after truncation.
    always_comb begin
        product = 64'(level_i) * 64'(SPEEDTICKER_STEP);
        diff    = {1'b0, DW'(SPEEDTICKER_BASE_LIMIT)} - XW'(product);
        borrow  = diff[XW-1] || (product > 64'(SPEEDTICKER_BASE_LIMIT));
        if (borrow || (diff < XW'(SPEEDTICKER_MIN_LIMIT))) begin
            limit_o = DW'(SPEEDTICKER_MIN_LIMIT);
        end else begin
            limit_o = diff[DW-1:0];
        end
    end

endmodule

// File: rtl/cc_speedticker.sv
// Speed timebase: enable-gated period counter with a SETUP/STROBE/RUN limit
// handshake, per-period tick and level-up every TICKS_PER_LEVEL ticks.
module cc_speedticker
    import cc_speedticker_pkg::*;
#(
    parameter int unsigned SPEEDTICKER_DATAWIDTH       = DEFAULT_DATAWIDTH,
    parameter int unsigned SPEEDTICKER_LEVELWIDTH      = DEFAULT_LEVELWIDTH,
    parameter int unsigned SPEEDTICKER_BASE_LIMIT      = DEFAULT_BASE_LIMIT,
    parameter int unsigned SPEEDTICKER_STEP            = DEFAULT_STEP,
    parameter int unsigned SPEEDTICKER_MIN_LIMIT       = DEFAULT_MIN_LIMIT,
    parameter int unsigned SPEEDTICKER_TICKS_PER_LEVEL = DEFAULT_TICKS_PER_LEVEL
) (
    input  logic                              CC_SPEEDTICKER_CLOCK_50,
    input  logic                              CC_SPEEDTICKER_RESET_InHigh,
    input  logic                              CC_SPEEDTICKER_enable_InHigh,
    input  logic                              CC_SPEEDTICKER_restart_InHigh,
    output logic [SPEEDTICKER_DATAWIDTH-1:0]  CC_SPEEDTICKER_data_OutBUS,
    output logic [SPEEDTICKER_DATAWIDTH-1:0]  CC_SPEEDTICKER_limit_OutBUS,
    output logic                              CC_SPEEDTICKER_loadSignal_OutLow,
    output logic                              CC_SPEEDTICKER_tick_OutHigh,
    output logic [SPEEDTICKER_LEVELWIDTH-1:0] CC_SPEEDTICKER_level_OutBUS,
    output logic                              CC_SPEEDTICKER_maxLevel_OutHigh
);

    localparam int unsigned DW  = SPEEDTICKER_DATAWIDTH;
    localparam int unsigned LW  = SPEEDTICKER_LEVELWIDTH;
    localparam int unsigned TCW = (SPEEDTICKER_TICKS_PER_LEVEL > 1) ?
                                  $clog2(SPEEDTICKER_TICKS_PER_LEVEL) : 1;
    localparam logic [LW-1:0]  LEVEL_MAX = '1;
    localparam logic [TCW-1:0] TICK_LAST = TCW'(SPEEDTICKER_TICKS_PER_LEVEL - 1);

    state_e         state_q;
    logic [DW-1:0]  count_q;
    logic [DW-1:0]  limit_q;
    logic           load_q;
    logic           tick_q;
    logic [LW-1:0]  level_q;
    logic           maxLevel_q;
    logic [TCW-1:0] tickCount_q;

    logic [LW-1:0]  levelNext_d;
    logic [DW-1:0]  limitNext_d;

    assign levelNext_d = level_q + LW'(1);

    cc_speedticker_limitcalc #(
        .SPEEDTICKER_DATAWIDTH  (SPEEDTICKER_DATAWIDTH),
        .SPEEDTICKER_LEVELWIDTH (SPEEDTICKER_LEVELWIDTH),
        .SPEEDTICKER_BASE_LIMIT (SPEEDTICKER_BASE_LIMIT),
        .SPEEDTICKER_STEP       (SPEEDTICKER_STEP),
        .SPEEDTICKER_MIN_LIMIT  (SPEEDTICKER_MIN_LIMIT)
    ) u_limitcalc (
        .level_i (levelNext_d),
        .limit_o (limitNext_d)
    );

    // Limit only changes on the edge that enters SETUP, so it is settled a
    // full cycle before the load strobe falls in STROBE.
    always_ff @(posedge CC_SPEEDTICKER_CLOCK_50) begin
        if (CC_SPEEDTICKER_RESET_InHigh || CC_SPEEDTICKER_restart_InHigh) begin
            state_q     <= ST_SETUP;
            count_q     <= '0;
            limit_q     <= DW'(SPEEDTICKER_BASE_LIMIT);
            load_q      <= 1'b1;
            tick_q      <= 1'b0;
            level_q     <= '0;
            maxLevel_q  <= 1'b0;
            tickCount_q <= '0;
        end else begin
            case (state_q)
                ST_SETUP: begin
                    state_q <= ST_STROBE;
                    load_q  <= 1'b0;
                    tick_q  <= 1'b0;
                    count_q <= '0;
                end
                ST_STROBE: begin
                    state_q <= ST_RUN;
                    load_q  <= 1'b1;
                    tick_q  <= 1'b0;
                    count_q <= '0;
                end
                ST_RUN: begin
                    if (!CC_SPEEDTICKER_enable_InHigh) begin
                        tick_q <= 1'b0;
                    end else if (count_q >= limit_q) begin
                        count_q <= '0;
                        tick_q  <= 1'b1;
                        if ((level_q != LEVEL_MAX) && (tickCount_q == TICK_LAST)) begin
                            level_q     <= levelNext_d;
                            limit_q     <= limitNext_d;
                            maxLevel_q  <= (levelNext_d == LEVEL_MAX);
                            tickCount_q <= '0;
                            state_q     <= ST_SETUP;
                        end else if (level_q == LEVEL_MAX) begin
                            tickCount_q <= '0;
                        end else begin
                            tickCount_q <= tickCount_q + TCW'(1);
                        end
                    end else begin
                        count_q <= count_q + DW'(1);
                        tick_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_SETUP;
                end
            endcase
        end
    end

    assign CC_SPEEDTICKER_data_OutBUS       = count_q;
    assign CC_SPEEDTICKER_limit_OutBUS      = limit_q;
    assign CC_SPEEDTICKER_loadSignal_OutLow = load_q;
    assign CC_SPEEDTICKER_tick_OutHigh      = tick_q;
    assign CC_SPEEDTICKER_level_OutBUS      = level_q;
    assign CC_SPEEDTICKER_maxLevel_OutHigh  = maxLevel_q;

endmodule

// File: doc/cc_speedticker.md
# cc_speedticker

Speed-timebase generator for the game datapath: free-running, enable-gated counter that produces the count bus, the current speed limit and the active-low limit-load strobe consumed by the speed comparator. It also emits a one-cycle tick per period. It raises the speed level, shortening the period, every fixed number of ticks. It sits between the top-level control FSM (enable/restart) and the speed comparator plus game-step logic.

## Interface
- SPEEDTICKER_DATAWIDTH, 28: width of count and limit buses
- SPEEDTICKER_LEVELWIDTH, 3: width of level; max level = 2^LEVELWIDTH-1
- SPEEDTICKER_BASE_LIMIT, 50_000_000: limit at level 0
- SPEEDTICKER_STEP, 5_000_000: limit decrement per level
- SPEEDTICKER_MIN_LIMIT, 5_000_000: floor of limit
- SPEEDTICKER_TICKS_PER_LEVEL, 8: ticks per level-up (>=1)

Ports:
- CC_SPEEDTICKER_CLOCK_50  in  1  single clock, all logic on rising edge
- CC_SPEEDTICKER_RESET_InHigh  in  1  reset, synchronous, active-high
- CC_SPEEDTICKER_enable_InHigh  in  1  count enable (pause when low)
- CC_SPEEDTICKER_restart_InHigh  in  1  synchronous game restart (level 0)
- CC_SPEEDTICKER_data_OutBUS  out  DATAWIDTH  current count
- CC_SPEEDTICKER_limit_OutBUS  out  DATAWIDTH  current limit
- CC_SPEEDTICKER_loadSignal_OutLow  out  1  one-cycle low strobe; limit stable around it
- CC_SPEEDTICKER_tick_OutHigh  out  1  one-cycle pulse per period
- CC_SPEEDTICKER_level_OutBUS  out  LEVELWIDTH  current speed level
- CC_SPEEDTICKER_maxLevel_OutHigh  out  1  level == max

## Operation
- All outputs are registered. Reset values: data 0, limit BASE_LIMIT, loadSignal 1, tick 0, level 0, maxLevel 0, tick counter 0, state SETUP.
- FSM states: SETUP -> STROBE -> RUN.
  - SETUP: limit is already valid and loadSignal is 1. Next state is STROBE unconditionally.
  - STROBE: loadSignal is 0. Next state is RUN unconditionally.
  - Count is held at 0 in SETUP and STROBE, and enable is ignored.
- RUN with enable=1:
  - If count >= limit: count <= 0 and tick <= 1. Otherwise count <= count+1.
- RUN with enable=0: count holds, tick <= 0.
- On each tick in RUN:
  - If tickCount == TICKS_PER_LEVEL-1 and level < max: level <= level+1, limit <= f(level+1), tickCount <= 0, state <= SETUP.
  - Otherwise tickCount increments.
  - At max level, tickCount is held at 0 and no further level-up occurs.
- Limit function: f(L) = BASE_LIMIT - L*STEP.
  - Compute in DATAWIDTH+1 bits.
  - On borrow, or a result below MIN_LIMIT, the limit is MIN_LIMIT.
- Restart: same effect as reset (state SETUP, level 0, limit BASE_LIMIT, count 0, tick 0).
- Priority: RESET > restart > level-up > count.
- Restart coinciding with a tick: restart wins, tick stays 0.
- Enable falling in the same cycle that count == limit: no wrap, no tick; count holds at limit.
  - The comparator output therefore stays low until enable returns.
- maxLevel is registered and equals (level == 2^LEVELWIDTH-1).

## Timing
- After reset is released: cycle 0 is SETUP, cycle 1 is STROBE (loadSignal=0), cycle 2 is RUN with count 0.
- Limit changes only on the edge entering SETUP. It is therefore stable one full cycle before and during the loadSignal falling edge, which gives the comparator a race-free latch.
- Period with continuous enable: limit+1 cycles (count 0..limit).
  - The comparator sees data >= limit for exactly one cycle.
  - tick is high in the cycle after count == limit, i.e. when count shows 0.
- Level-up adds 2 cycles (SETUP, STROBE) before counting resumes from 0.
- Latency: restart asserted at edge N gives SETUP state at N+1 and loadSignal low at N+2.

## Structure
- Shared package: state encoding (SETUP, STROBE, RUN) and the default BASE/STEP/MIN constants.
- One sub-module: cc_speedticker_limitcalc, purely combinational. Input is a level; output is a clamped limit. It is the only place implementing f(L), so its boundaries can be verified standalone.
- Main module: FSM, count register, tickCount register, output registers.

## Test plan
All scenarios use BASE_LIMIT=10, STEP=3, MIN_LIMIT=4, TICKS_PER_LEVEL=2, LEVELWIDTH=2, DATAWIDTH=8.
- Reset then enable=1:
  - limit=10; loadSignal low exactly in cycle 1 after reset release.
  - Count runs 0..10; tick every 11 cycles.
- Continuous enable through levels:
  - After 2 ticks: level 1, limit 7, period 8.
  - After 2 more: level 2, limit 4, period 5.
  - Next: level 3, limit clamped to 4, maxLevel=1.
  - Level stays 3 after further ticks.
  - Each level change shows the SETUP/STROBE gap of 2 cycles with count 0.
- Pause at count=5: count holds at 5 for the whole pause, no tick; resumes at 6 when enable returns.
- Enable dropped on the cycle where count==10: count stays 10, no tick. Re-enabling wraps to 0 with tick on the next cycle.
- Restart at level 2 on the same cycle as a tick:
  - tick=0, level 0, limit 10, loadSignal low 2 cycles later.
- Reset asserted mid-STROBE: next cycle shows all reset values (loadSignal=1, state SETUP).
